// File: rtl/pxl_reg_loader.sv
// Block loader: reads 4-word groups from a sync-read image memory and issues pixel/multiplier
// register write pulses. Define PXL_LOADER_BYTE_SWAP_EN to byte-reverse each fetched word.
module pxl_reg_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              load_mul,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              we_pxl,
  output logic              wr_pos_pxl,
  output logic [DATA_W-1:0] wdp1,
  output logic [DATA_W-1:0] wdp2,
  output logic [DATA_W-1:0] wdp3,
  output logic [DATA_W-1:0] wdp4,
  output logic              we_mul,
  output logic              wr_mul_pos,
  output logic [DATA_W-1:0] wdm1,
  output logic [DATA_W-1:0] wdm2,
  output logic [DATA_W-1:0] wdm3,
  output logic [DATA_W-1:0] wdm4,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                load_mul_q, load_mul_d;
  logic [1:0]          grp_q, grp_d;
  logic [1:0]          word_q, word_d;
  logic                cap_vld_q, cap_vld_d;
  logic [1:0]          cap_idx_q, cap_idx_d;
  logic [DATA_W-1:0]   lane_q [4];
  logic [DATA_W-1:0]   lane_d [4];
  logic [DATA_W-1:0]   wdp_q [4];
  logic [DATA_W-1:0]   wdp_d [4];
  logic [DATA_W-1:0]   wdm_q [4];
  logic [DATA_W-1:0]   wdm_d [4];
  logic [DATA_W-1:0]   cap_word;

`ifdef PXL_LOADER_BYTE_SWAP_EN
  function automatic logic [DATA_W-1:0] swap_bytes(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      r[8*i +: 8] = w[DATA_W-8-8*i +: 8];
    end
    return r;
  endfunction
  assign cap_word = swap_bytes(mem_rdata);
`else
  assign cap_word = mem_rdata;
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    load_mul_d = load_mul_q;
    grp_d      = grp_q;
    word_d     = word_q;
    cap_vld_d  = 1'b0;
    cap_idx_d  = word_q;
    lane_d     = lane_q;
    wdp_d      = wdp_q;
    wdm_d      = wdm_q;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    we_pxl     = 1'b0;
    wr_pos_pxl = 1'b0;
    we_mul     = 1'b0;
    wr_mul_pos = 1'b0;
    busy       = (state_q != StIdle);
    done       = 1'b0;

    // Read data arrives one cycle after its strobe; land it in the lane of that read.
    if (cap_vld_q) begin
      lane_d[cap_idx_q] = cap_word;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d     = base_addr;
          load_mul_d = load_mul;
          grp_d      = 2'd0;
          word_d     = 2'd0;
          state_d    = StRead;
        end
      end
      StRead: begin
        mem_rd    = 1'b1;
        mem_addr  = base_q + ADDR_W'({grp_q, word_q});
        cap_vld_d = 1'b1;
        word_d    = word_q + 2'd1;
        if (word_q == 2'd3) begin
          state_d = StWait;
        end
      end
      StWait: begin
        // Last lane lands this edge, so the output bank is loaded alongside it.
        if (grp_q[1]) begin
          wdm_d = lane_d;
        end else begin
          wdp_d = lane_d;
        end
        state_d = StWrite;
      end
      StWrite: begin
        we_pxl     = ~grp_q[1];
        wr_pos_pxl = ~grp_q[1] & grp_q[0];
        we_mul     = grp_q[1];
        wr_mul_pos = grp_q[1] & grp_q[0];
        if (grp_q == (load_mul_q ? 2'd3 : 2'd1)) begin
          state_d = StDone;
        end else begin
          grp_d   = grp_q + 2'd1;
          state_d = StRead;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      load_mul_q <= 1'b0;
      grp_q      <= 2'd0;
      word_q     <= 2'd0;
      cap_vld_q  <= 1'b0;
      cap_idx_q  <= 2'd0;
      lane_q     <= '{default: '0};
      wdp_q      <= '{default: '0};
      wdm_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      load_mul_q <= load_mul_d;
      grp_q      <= grp_d;
      word_q     <= word_d;
      cap_vld_q  <= cap_vld_d;
      cap_idx_q  <= cap_idx_d;
      lane_q     <= lane_d;
      wdp_q      <= wdp_d;
      wdm_q      <= wdm_d;
    end
  end

  assign wdp1 = wdp_q[0];
  assign wdp2 = wdp_q[1];
  assign wdp3 = wdp_q[2];
  assign wdp4 = wdp_q[3];
  assign wdm1 = wdm_q[0];
  assign wdm2 = wdm_q[1];
  assign wdm3 = wdm_q[2];
  assign wdm4 = wdm_q[3];

endmodule

// File: doc/pxl_reg_loader.md
Name: pxl_reg_loader

Overview:
- Memory-side producer for the vector CPU's pixel and multiplier register write ports (we_pxl/wr_pos_pxl/wdp1..4 and we_mul/wr_mul_pos/wdm1..4).
- On a start request, fetches a block of 32-bit packed-pixel words from a synchronous-read image memory and assembles them into 4-lane groups.
- Issues one register-write pulse per group. Replaces hand-driven register preloading ahead of IF/ID/EXE execution.

Parameters:
- ADDR_W, 10, memory word-address width; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 32, memory word and register lane width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  load request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address of the block; latched on accepted start.
- load_mul  in  1  also load the multiplier bank; latched on accepted start.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd.
- we_pxl  out  1  pixel register write pulse.
- wr_pos_pxl  out  1  pixel register half select (0/1).
- wdp1..wdp4  out  DATA_W each  pixel lane data.
- we_mul  out  1  multiplier register write pulse.
- wr_mul_pos  out  1  multiplier register half select.
- wdm1..wdm4  out  DATA_W each  multiplier lane data.
- busy  out  1  high from accepted start through the DONE cycle.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset (rst=0 at an edge): state IDLE. All outputs 0, including wdp*/wdm*, counters and lane buffers. Takes priority over every other event.
- Block layout, relative to latched base B:
  - B+0..3: pxl pos0, lanes 1..4
  - B+4..7: pxl pos1
  - B+8..11: mul pos0
  - B+12..15: mul pos1 (mul groups only if load_mul latched 1)
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
  - IDLE: busy=0. start=1 latches B and load_mul, clears group/word counters, goes to READ.
  - READ: 4 cycles. Each cycle mem_rd=1, mem_addr = B + 4*grp + w (w=0..3). The word returned for read w is captured into lane w+1 on the following edge. Goes to WAIT after w=3.
  - WAIT: 1 cycle. mem_rd=0; lane 4 is captured.
  - WRITE: 1 cycle. Registered lane data is presented on wdp1..4 (grp 0/1) or wdm1..4 (grp 2/3).
    - grp 0/1: we_pxl=1, wr_pos_pxl=grp[0].
    - grp 2/3: we_mul=1, wr_mul_pos=grp[0].
    - Next state is READ with grp+1 if more groups remain, else DONE.
  - DONE: 1 cycle, done=1 and busy=1, then IDLE.
- Timing, with cycle 0 = the edge accepting start:
  - READ cycles 6g+1..6g+4, WAIT 6g+5, WRITE 6g+6.
  - DONE at cycle 13 (load_mul=0) or 25 (load_mul=1).
- wdp*/wdm* hold their last written values between writes. Write enables and mem_rd are 0 outside the states above.
- we_pxl and we_mul are never high together; each write pulse is exactly 1 cycle.
- start while busy=1 is ignored; no queuing. start in the DONE cycle is also ignored.
- Address wrap: B+offset wraps modulo 2^ADDR_W with no error.
- Reset mid-operation: abort immediately, issue no further write pulses, return to IDLE. A previously completed group write stays visible in the register file only; the outputs here go to 0.

Optional Feature:
- Macro: PXL_LOADER_BYTE_SWAP_EN.
- Defined: each captured word is byte-reversed before entering the lane buffer ({b0,b1,b2,b3}), for little-endian image memories. Timing is unchanged.
- Undefined: words pass through unmodified.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 -> all outputs 0, busy=0, mem_rd=0; no start is accepted.
- Pixel-only load: B=0x010, load_mul=0, mem[0x010..0x017] = 416D5267, 416D5263, 415D5267, 426D5267, 416D5367, 416C5263, 415D5267, 426D506B.
  - mem_addr = 0x010..0x013 at cycles 1-4.
  - Cycle 6: we_pxl=1, wr_pos_pxl=0, wdp1..4 = first four words.
  - Cycle 12: we_pxl=1, wr_pos_pxl=1, wdp1..4 = last four words.
  - done=1 at cycle 13; we_mul never asserted.
- Full load: B=0x020, load_mul=1, mem[0x028..0x02F] = 416D5267, 416D5263, 415D5267, 426D5267 repeated.
  - Cycles 6 and 12: we_pxl pulses.
  - Cycle 18: we_mul=1, wr_mul_pos=0, wdm1..4 = 416D5267, 416D5263, 415D5267, 426D5267.
  - Cycle 24: we_mul=1, wr_mul_pos=1.
  - Cycle 25: done=1.
- Wrap: B=0x3FE (ADDR_W=10) -> mem_addr sequence 3FE, 3FF, 000, 001, then 002..005; lane data matches the wrapped locations.
- Busy/abort:
  - start=1 again at cycle 3 -> ignored; the sequence is unchanged.
  - In a new run, rst=0 at cycle 8 -> no we_pxl at cycle 12, outputs 0.
  - A following start works normally from cycle 0.
- Macro (PXL_LOADER_BYTE_SWAP_EN defined): mem word 416D5267 -> wdp1 = 67526D41 at the first write.
